// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, ROM sampling and a decode-side FIFO with redirect flush.
// Optional FETCH_MISALIGN_FAULT_EN: a misaligned redirect yields one fault entry, then fetch halts.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_rdata,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_instr,
  output logic                  out_fault
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] fetch_pc;
  logic [PW:0] rptr, wptr;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] load_pc;
  logic halted, fault_pend;
  logic empty, full, pop, push;
  assign empty = rptr == wptr;
  assign full = (rptr[PW] != wptr[PW]) && (rptr[PW-1:0] == wptr[PW-1:0]);
  assign pop = !empty && out_ready;
  assign push = !redirect_valid && (!halted || fault_pend) && (!full || pop);
  assign rom_addr = fetch_pc[ADDR_WIDTH-1:0];
  assign out_valid = !empty;
  assign out_pc = empty ? 32'h0 : pc_mem[rptr[PW-1:0]];
  assign out_instr = empty ? 32'h0 : instr_mem[rptr[PW-1:0]];
`ifdef FETCH_MISALIGN_FAULT_EN
  logic [DEPTH-1:0] fault_mem;
  logic misalign;
  assign misalign = |redirect_pc[1:0];
  assign load_pc = redirect_pc;
  assign out_fault = !empty && fault_mem[rptr[PW-1:0]];
  // halted with fault_pend set means the fault entry is still owed to the queue
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      halted <= 1'b0;
      fault_pend <= 1'b0;
    end else if (redirect_valid) begin
      halted <= misalign;
      fault_pend <= misalign;
    end else if (push) fault_pend <= 1'b0;
  always_ff @(posedge clk)
    if (push) fault_mem[wptr[PW-1:0]] <= fault_pend;
`else
  assign load_pc = redirect_pc & ~32'h3;
  assign halted = 1'b0;
  assign fault_pend = 1'b0;
  assign out_fault = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc <= RESET_PC;
      rptr <= '0;
      wptr <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= load_pc;
      rptr <= wptr;
    end else begin
      if (pop) rptr <= rptr + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (push && !fault_pend) fetch_pc <= fetch_pc + 32'd4;
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wptr[PW-1:0]] <= fetch_pc;
      instr_mem[wptr[PW-1:0]] <= fault_pend ? 32'h0 : rom_rdata;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the RISC-V core. It owns the fetch PC and drives the instruction-side address port of the dual-read word ROM, sampling the ROM's combinational read data in the same cycle. Fetched {pc, instruction} pairs go into a small FIFO that presents them to decode through a valid/ready handshake. Execute can redirect fetch, which flushes the queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.
- `ADDR_WIDTH`, default 12: ROM byte-address width, equal to $clog2(ROM SIZE).
- `DEPTH`, default 4: queue entries; a power of two, at least 2.
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rom_addr`, output, ADDR_WIDTH: byte address to the ROM instruction port; equals fetch_pc[ADDR_WIDTH-1:0].
- `rom_rdata`, input, 32: ROM word for `rom_addr`, valid combinationally in the same cycle.
- `redirect_valid`, input, 1: load a new fetch PC and flush the queue.
- `redirect_pc`, input, 32: redirect target.
- `out_valid`, output, 1: queue head is valid.
- `out_ready`, input, 1: decode accepts the head.
- `out_pc`, output, 32: PC of the head entry.
- `out_instr`, output, 32: instruction word of the head entry.
- `out_fault`, output, 1: the head entry is a fetch fault (see Configuration).

## Operation
- State:
  - fetch_pc, 32 bits.
  - Queue of DEPTH entries {pc[31:0], instr[31:0], fault}, with read/write pointers of $clog2(DEPTH)+1 bits.
  - halted flag, used only with the macro.
- Reset values:
  - fetch_pc = RESET_PC; queue empty; halted = 0.
  - out_valid = 0; out_pc = 0; out_instr = 0; out_fault = 0.
  - Whenever the queue is empty, out_pc, out_instr and out_fault read 0.
- Pop: occurs when out_valid && out_ready; the read pointer advances.
- Push: occurs when !redirect_valid && !halted && (!full || pop). The entry is {fetch_pc, rom_rdata, 0}, and fetch_pc advances by 4.
- Push and pop in the same cycle are legal when full. Sustained throughput is 1 instruction per cycle.
- Redirect, when redirect_valid = 1, has priority over push:
  - All entries are discarded (read pointer set to write pointer), but a handshake in that same cycle still completes. Decode is responsible for killing that entry.
  - fetch_pc = redirect_pc; halted = 0; no push that cycle.
  - If redirect_valid is held for several cycles, each cycle re-flushes and reloads fetch_pc.
- Arithmetic:
  - fetch_pc + 4 wraps modulo 2^32.
  - rom_addr truncates to ADDR_WIDTH bits, so fetch wraps around within the ROM image.
  - The pointer MSB distinguishes full from empty.
- `rom_addr` always reflects fetch_pc, including while full or halted. The ROM has no side effects on reads.

## Timing
- Fetch-to-visible latency: a word fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- After rst deasserts, the first fetch happens in the first clock cycle, and out_valid rises 1 cycle later with out_pc = RESET_PC.
- Redirect asserted in cycle N:
  - out_valid = 0 in cycle N+1.
  - The target is fetched in cycle N+1.
  - out_valid = 1 with out_pc = target in cycle N+2.
- When full and not popping, a push is blocked and fetch_pc holds.
- rst asserted mid-operation immediately clears the queue and outputs, independent of clk.
- out_* are driven from registered state. The only combinational path is rom_rdata into the queue write data.

## Configuration
- `FETCH_MISALIGN_FAULT_EN` defined:
  - A redirect with redirect_pc[1:0] != 0 loads fetch_pc = redirect_pc and sets halted = 1 in place of normal fetching.
  - The next cycle pushes one entry {redirect_pc, 32'h0, fault = 1}.
  - No further pushes occur until the next redirect.
  - The fault entry obeys the normal handshake.
- `FETCH_MISALIGN_FAULT_EN` undefined:
  - redirect_pc[1:0] is forced to 2'b00 when loaded.
  - halted is constantly 0 and out_fault is tied to 0.

## Test plan
- Reset with RESET_PC = 0, ROM words 0..7 = 32'h1000_0000 + index, out_ready = 1 -> from cycle 1, one entry per cycle with out_pc = 0, 4, 8, … and out_instr = 32'h1000_0000, 32'h1000_0001, ….
- out_ready = 0 for 10 cycles -> queue holds DEPTH = 4 entries (PCs 0–12) and fetch_pc sticks at 16; raising out_ready then gives PCs 0, 4, … with no gap or duplicate.
- Redirect to 32'h40 while full, with out_ready = 1 in the same cycle -> the head is popped, the rest is flushed, out_valid = 0 for one cycle, then out_pc = 32'h40, 32'h44.
- fetch_pc = 32'hFFC with ADDR_WIDTH = 12 -> rom_addr = 12'hFFC, and next rom_addr = 12'h000 with out_pc = 32'h1000.
- Redirect to 32'h42:
  - With the macro defined -> a single entry {pc = 32'h42, instr = 0, fault = 1}, then out_valid = 0 until a redirect to 32'h0 resumes fetching.
  - With the macro undefined -> out_pc = 32'h40 and out_fault = 0.
- rst asserted asynchronously mid-stream -> out_valid = 0 with no clock edge; after release, out_pc = RESET_PC.
